// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR filter with one shared multiply-accumulate.
// Each accepted sample is shifted into a TAPS-deep delay line. The block then
// spends TAPS cycles in MAC summing x[k]*h[k], and holds the result in OUT
// until the sink takes it.
// Optional feature: define FIR_SAT_EN to clamp the shifted result to the
// OUT_W signed range. If it is not defined, the result wraps to OUT_W bits.
//
// Handshake rule, used on both ports: a transfer happens on a rising clk edge
// where valid and ready are both high. Once the producer raises valid, it holds
// valid and its data stable until that edge. in_ready is high only in IDLE.
// out_valid is high only in OUT.
module fir_serial_mac #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0,
  parameter int AW        = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] h [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            idx;

  logic                     accept;
  logic                     last_tap;
  logic                     coef_take;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  result;

  assign accept    = in_valid && (state == IDLE);
  assign last_tap  = (idx == AW'(TAPS - 1));
  assign coef_take = coef_we && (state != MAC) &&
                     ({1'b0, coef_addr} < (AW + 1)'(TAPS));

  // Full-precision product and running sum. The accumulator has AW guard bits,
  // so adding TAPS products can never overflow.
  always_comb begin
    prod    = PROD_W'(x[idx]) * PROD_W'(h[idx]);
    sum     = acc + ACC_W'(prod);
    shifted = sum >>> OUT_SHIFT;
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp the shifted sum to the signed OUT_W range.
  always_comb begin
    result = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) result = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[OUT_W-1:0];
  end
`else
  logic unused_high_bits;
  assign unused_high_bits = ^shifted[ACC_W-1:OUT_W];

  // Two's-complement wrap: keep only the low OUT_W bits.
  always_comb begin
    result = shifted[OUT_W-1:0];
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (last_tap) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Delay line: shifts only when a sample is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (accept) begin
      for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
      x[0] <= in_data;
    end
  end

  // Coefficient bank. Reset loads the identity filter. Writes are dropped
  // during MAC, so one output never mixes two coefficient sets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) h[k] <= (k == 0) ? COEF_W'(1) : '0;
    end else if (coef_take) begin
      h[coef_addr] <= coef_data;
    end
  end

  // Accumulator and tap index: cleared on accept, stepped once per MAC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      acc <= '0;
      idx <= '0;
    end else if (state == MAC) begin
      acc <= sum;
      idx <= idx + AW'(1);
    end
  end

  // Output register: loaded only on the last MAC cycle, so it stays stable in OUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       out_data <= '0;
    else if (state == MAC && last_tap) out_data <= result;
  end

endmodule
